// File: rtl/decoder_pkg.sv
// Shared constants and width helper for the one-hot decoder family.
// Used by the RTL and by its testbench.
package decoder_pkg;

  localparam int MAX_IN_W = 8;
  localparam int CELL_W   = 2;

  function automatic int onehot_width(input int in_w);
    return 1 << in_w;
  endfunction

endpackage

// File: rtl/dec2to4_cell.sv
// 2-to-4 predecode cell: purely combinational binary-to-one-hot on a 2-bit field.
module dec2to4_cell (
  input  logic [1:0] sel,
  output logic [3:0] onehot
);

  always_comb begin
    onehot = 4'b0000;
    case (sel)
      2'b00:   onehot = 4'b0001;
      2'b01:   onehot = 4'b0010;
      2'b10:   onehot = 4'b0100;
      default: onehot = 4'b1000;
    endcase
  end

endmodule

// File: rtl/onehot_decoder_reg.sv
// Registered binary-to-one-hot decoder built from 2-to-4 predecode cells
// combined through an AND-matrix; one cycle latency, full throughput.
module onehot_decoder_reg
  import decoder_pkg::*;
#(
  parameter int IN_W  = 4,
  parameter int OUT_W = onehot_width(IN_W)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [IN_W-1:0]  in_idx,
  output logic [OUT_W-1:0] out_onehot,
  output logic             out_valid
);

  localparam int NCELL = IN_W / CELL_W;

  if (IN_W < CELL_W || IN_W > MAX_IN_W || (IN_W % CELL_W) != 0) begin : g_bad_in_w
    $error("onehot_decoder_reg: IN_W must be even and in 2..8");
  end
  if (OUT_W != onehot_width(IN_W)) begin : g_bad_out_w
    $error("onehot_decoder_reg: OUT_W is derived from IN_W and must not be overridden");
  end

  logic [NCELL-1:0][3:0] cell_out;
  logic [OUT_W-1:0]      onehot_p0;
  logic [OUT_W-1:0]      onehot_p1;
  logic                  vld_p1;

  // Stage p0: predecode each 2-bit field of the index
  for (genvar gk = 0; gk < NCELL; gk++) begin : g_cell
    dec2to4_cell u_cell (
      .sel    (in_idx[CELL_W*gk +: CELL_W]),
      .onehot (cell_out[gk])
    );
  end

  // Output bit i is the AND of each cell's line selected by the matching field of i
  for (genvar gi = 0; gi < OUT_W; gi++) begin : g_bit
    logic [NCELL-1:0] terms;
    for (genvar gk = 0; gk < NCELL; gk++) begin : g_term
      localparam int unsigned FIELD = (gi >> (CELL_W * gk)) % 4;
      assign terms[gk] = cell_out[gk][FIELD];
    end
    assign onehot_p0[gi] = &terms;
  end

  // Stage p1: output registers; a disabled cycle clears the word so nothing stale lingers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      onehot_p1 <= '0;
      vld_p1    <= 1'b0;
    end else if (en) begin
      onehot_p1 <= onehot_p0;
      vld_p1    <= 1'b1;
    end else begin
      onehot_p1 <= '0;
      vld_p1    <= 1'b0;
    end
  end

  assign out_onehot = onehot_p1;
  assign out_valid  = vld_p1;

endmodule

// File: tb/tb_onehot_decoder_reg.sv
// Scoreboard bench for onehot_decoder_reg: IN_W=4 and IN_W=2 instances driven
// in lockstep, expected words queued at stimulus time and popped by a monitor.
module tb_onehot_decoder_reg;
  import decoder_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        en;
  logic [3:0]  idx4;
  logic [1:0]  idx2;
  logic [15:0] oh4;
  logic        v4;
  logic [3:0]  oh2;
  logic        v2;

  onehot_decoder_reg #(.IN_W(4)) u_dut4 (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .in_idx     (idx4),
    .out_onehot (oh4),
    .out_valid  (v4)
  );

  onehot_decoder_reg #(.IN_W(2)) u_dut2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .in_idx     (idx2),
    .out_onehot (oh2),
    .out_valid  (v2)
  );

  typedef struct packed {
    logic [15:0] oh;
    logic        v;
  } exp_t;

  exp_t q4[$];
  exp_t q2[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at t=%0t", name, act, req, $time);
    end
  endtask

  // Reference model: a decode of an enabled, non-reset cycle is 2**idx; anything else is empty.
  function automatic exp_t model(input logic r, input logic e, input int idx, input int out_w);
    exp_t x;
    x.v  = r && e;
    x.oh = '0;
    if (x.v) begin
      x.oh = 16'(1) << idx;
      if (idx >= out_w) x.oh = '0;
    end
    return x;
  endfunction

  task automatic step(input logic r, input logic e, input logic [3:0] i4, input logic [1:0] i2);
    @(negedge clk);
    rst_n = r;
    en    = e;
    idx4  = i4;
    idx2  = i2;
    q4.push_back(model(r, e, int'(i4), onehot_width(4)));
    q2.push_back(model(r, e, int'(i2), onehot_width(2)));
  endtask

  // Monitor: compare every presented output and check the one-hot invariants.
  always @(posedge clk) begin
    exp_t e4;
    exp_t e2;
    #1;
    if (q4.size() > 0) begin
      e4 = q4.pop_front();
      chk("onehot4", oh4, e4.oh);
      chk("valid4", {15'b0, v4}, {15'b0, e4.v});
    end
    if (q2.size() > 0) begin
      e2 = q2.pop_front();
      chk("onehot2", {12'b0, oh2}, e2.oh);
      chk("valid2", {15'b0, v2}, {15'b0, e2.v});
    end
    chk("inv_pop4", 16'($countones(oh4) <= 1), 16'd1);
    chk("inv_vld4", {15'b0, v4}, 16'($countones(oh4) == 1));
    chk("inv_pop2", 16'($countones(oh2) <= 1), 16'd1);
    chk("inv_vld2", {15'b0, v2}, 16'($countones(oh2) == 1));
  end

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    idx4  = 4'h0;
    idx2  = 2'b00;

    repeat (3) step(1'b0, 1'b1, 4'h5, 2'b01);
    step(1'b1, 1'b1, 4'h5, 2'b01);

    for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 4'(i), 2'(i));

    step(1'b1, 1'b1, 4'h3, 2'b11);
    step(1'b1, 1'b0, 4'h9, 2'b01);

    step(1'b1, 1'b1, 4'h1, 2'b01);
    step(1'b0, 1'b1, 4'h2, 2'b10);
    step(1'b1, 1'b1, 4'h4, 2'b00);

    for (int n = 0; n < 200; n++) begin
      logic r;
      logic e;
      r = ($urandom_range(0, 19) != 0);
      e = ($urandom_range(0, 3) != 0);
      step(r, e, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
    end

    step(1'b1, 1'b0, 4'h0, 2'b00);
    repeat (3) @(posedge clk);
    #2;
    chk("drain", 16'(q4.size() + q2.size()), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
